// File: rtl/eim_initiator_if.sv
// Host command/response handshake plus EIM pad-side signals for eim_initiator.
// master = the initiator's view, slave = host/target environment view.
interface eim_initiator_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_we;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_err;
  logic [7:0] rsp_rdata;
  logic       eim_bclk;
  logic       eim_cs0_n;
  logic       eim_lba_n;
  logic       eim_wr_n;
  logic       eim_oe_n;
  logic [7:0] eim_da_o;
  logic       eim_da_oe;
  logic [7:0] eim_da_i;
  logic       eim_wait_n;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, eim_da_i, eim_wait_n,
    output cmd_ready, rsp_valid, rsp_err, rsp_rdata,
    output eim_bclk, eim_cs0_n, eim_lba_n, eim_wr_n, eim_oe_n, eim_da_o, eim_da_oe
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, eim_da_i, eim_wait_n,
    input  cmd_ready, rsp_valid, rsp_err, rsp_rdata,
    input  eim_bclk, eim_cs0_n, eim_lba_n, eim_wr_n, eim_oe_n, eim_da_o, eim_da_oe
  );
endinterface

// File: rtl/eim_initiator.sv
// Async-mode EIM bus master: one-byte reads/writes over the muxed 8-bit DA bus,
// every phase stretched to a programmable number of clocks, with wait-stretch and timeout.
module eim_initiator #(
  parameter int unsigned PHASE_CYC = 4,
  parameter int unsigned TURN_CYC  = 2,
  parameter int unsigned WAIT_MAX  = 16
) (
  input logic            clk,
  input logic            rst,
  eim_initiator_if.master bus
);
  localparam int unsigned CNT_MAX = (PHASE_CYC > TURN_CYC) ? PHASE_CYC : TURN_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned WAIT_W  = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0]  PHASE_LD  = CNT_W'(PHASE_CYC - 1);
  localparam logic [CNT_W-1:0]  TURN_LD   = CNT_W'(TURN_CYC - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);
  localparam bit                WAIT_EN   = (WAIT_MAX != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LATCH, S_WDATA, S_WHOLD, S_TURN, S_RDATA, S_RECOV
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [WAIT_W-1:0]  r_wait_cnt, w_wait_nxt;
  logic               r_we;
  logic [7:0]         r_addr, r_wdata;
  logic               r_wait_s1, r_wait_s2;
  logic               w_cap, w_hold, w_waiting;
  logic [7:0]         w_addr;

  logic               r_cmd_ready, w_cmd_ready;
  logic               r_rsp_valid, w_rsp_valid;
  logic               r_rsp_err, w_rsp_err;
  logic [7:0]         r_rsp_rdata, w_rsp_rdata;
  logic               r_cs0_n, w_cs0_n;
  logic               r_lba_n, w_lba_n;
  logic               r_wr_n, w_wr_n;
  logic               r_oe_n, w_oe_n;
  logic               r_da_oe, w_da_oe;
  logic [7:0]         r_da_o, w_da_o;

  // Next state, phase/wait counters, response, and the registered pad values for the next state
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wait_nxt  = r_wait_cnt;
    w_cap       = 1'b0;
    w_hold      = 1'b0;
    w_rsp_valid = 1'b0;
    w_rsp_err   = r_rsp_err;
    w_rsp_rdata = r_rsp_rdata;
    w_waiting   = WAIT_EN && !r_wait_s2;

    case (r_state)
      S_IDLE:  if (bus.cmd_valid) begin
                 w_state_nxt = S_ADDR;
                 w_cap       = 1'b1;
               end
      S_ADDR:  if (r_cnt == '0) w_state_nxt = S_LATCH;
      S_LATCH: if (r_cnt == '0) w_state_nxt = r_we ? S_WDATA : S_TURN;
      S_WDATA, S_RDATA: begin
        if (w_waiting) begin
          if (r_wait_cnt == WAIT_LAST) begin
            w_state_nxt = S_RECOV;
            w_rsp_valid = 1'b1;
            w_rsp_err   = 1'b1;
            if (r_state == S_RDATA) w_rsp_rdata = 8'h00;
          end else begin
            w_hold     = 1'b1;
            w_wait_nxt = r_wait_cnt + WAIT_W'(1);
          end
        end else begin
          w_wait_nxt = '0;
          if (r_cnt == '0) begin
            if (r_state == S_WDATA) begin
              w_state_nxt = S_WHOLD;
            end else begin
              w_state_nxt = S_RECOV;
              w_rsp_valid = 1'b1;
              w_rsp_err   = 1'b0;
              w_rsp_rdata = bus.eim_da_i;
            end
          end
        end
      end
      S_WHOLD: if (r_cnt == '0) begin
                 w_state_nxt = S_RECOV;
                 w_rsp_valid = 1'b1;
                 w_rsp_err   = 1'b0;
               end
      S_TURN:  if (r_cnt == '0) w_state_nxt = S_RDATA;
      S_RECOV: if (r_cnt == '0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_state_nxt != r_state) begin
      w_cnt_nxt  = (w_state_nxt == S_TURN) ? TURN_LD : PHASE_LD;
      w_wait_nxt = '0;
    end else if (!w_hold && r_cnt != '0) begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
    end

    // Pads follow the state being entered so they are registered alongside it
    w_addr      = w_cap ? bus.cmd_addr : r_addr;
    w_cmd_ready = (w_state_nxt == S_IDLE);
    w_cs0_n     = 1'b1;
    w_lba_n     = 1'b1;
    w_wr_n      = 1'b1;
    w_oe_n      = 1'b1;
    w_da_oe     = 1'b0;
    w_da_o      = 8'h00;
    case (w_state_nxt)
      S_ADDR:  begin w_cs0_n = 1'b0; w_lba_n = 1'b0; w_da_oe = 1'b1; w_da_o = w_addr; end
      S_LATCH: begin w_cs0_n = 1'b0; w_da_oe = 1'b1; w_da_o = w_addr; end
      S_WDATA: begin w_cs0_n = 1'b0; w_wr_n = 1'b0; w_da_oe = 1'b1; w_da_o = r_wdata; end
      S_WHOLD: begin w_cs0_n = 1'b0; w_da_oe = 1'b1; w_da_o = r_wdata; end
      S_TURN:  w_cs0_n = 1'b0;
      S_RDATA: begin w_cs0_n = 1'b0; w_oe_n = 1'b0; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_wait_cnt  <= '0;
      r_we        <= 1'b0;
      r_addr      <= 8'h00;
      r_wdata     <= 8'h00;
      r_wait_s1   <= 1'b1;
      r_wait_s2   <= 1'b1;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 8'h00;
      r_cs0_n     <= 1'b1;
      r_lba_n     <= 1'b1;
      r_wr_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_da_oe     <= 1'b0;
      r_da_o      <= 8'h00;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_wait_cnt  <= w_wait_nxt;
      r_wait_s1   <= bus.eim_wait_n;
      r_wait_s2   <= r_wait_s1;
      if (w_cap) begin
        r_we    <= bus.cmd_we;
        r_addr  <= bus.cmd_addr;
        r_wdata <= bus.cmd_wdata;
      end
      r_cmd_ready <= w_cmd_ready;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_err   <= w_rsp_err;
      r_rsp_rdata <= w_rsp_rdata;
      r_cs0_n     <= w_cs0_n;
      r_lba_n     <= w_lba_n;
      r_wr_n      <= w_wr_n;
      r_oe_n      <= w_oe_n;
      r_da_oe     <= w_da_oe;
      r_da_o      <= w_da_o;
    end
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.eim_bclk  = 1'b0;
  assign bus.eim_cs0_n = r_cs0_n;
  assign bus.eim_lba_n = r_lba_n;
  assign bus.eim_wr_n  = r_wr_n;
  assign bus.eim_oe_n  = r_oe_n;
  assign bus.eim_da_oe = r_da_oe;
  assign bus.eim_da_o  = r_da_o;
endmodule

// File: tb/tb_eim_initiator.sv
// Bench for eim_initiator: directed protocol scenarios plus random traffic against a byte
// memory target, with a response scoreboard checking error, data and latency.
module tb_eim_initiator;
  localparam int unsigned P  = 4;
  localparam int unsigned T  = 2;
  localparam int unsigned WM = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eim_initiator_if bus();
  eim_initiator #(.PHASE_CYC(P), .TURN_CYC(T), .WAIT_MAX(WM)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic        we;
    logic        err;
    logic [7:0]  rdata;
    int unsigned lat;
    int unsigned acc;
  } exp_t;

  exp_t        sbq[$];
  logic [7:0]  ref_mem[256];
  logic [7:0]  last_rdata = 8'h00;
  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Simple byte-memory target: address on LBA rise, write on WR rise, drive on OE low
  logic [7:0] tmem[256];
  logic [7:0] taddr = 8'h00;
  logic       p_lba = 1'b1, p_wr = 1'b1;
  always @(negedge clk) begin
    if (p_lba === 1'b0 && bus.eim_lba_n === 1'b1 && bus.eim_cs0_n === 1'b0) taddr = bus.eim_da_o;
    if (p_wr === 1'b0 && bus.eim_wr_n === 1'b1 && bus.eim_cs0_n === 1'b0) tmem[taddr] = bus.eim_da_o;
    p_lba = bus.eim_lba_n;
    p_wr  = bus.eim_wr_n;
  end
  assign bus.eim_da_i = (bus.eim_oe_n === 1'b0) ? tmem[taddr] : 8'hEE;

  // Pad waveform bookkeeping
  int unsigned wr_run = 0, oe_run = 0, cs_run = 0;
  int unsigned last_wr = 0, last_oe = 0, last_gap = 0;
  int unsigned contention = 0, bclk_bad = 0;
  always @(negedge clk) begin
    if (bus.eim_wr_n === 1'b0) wr_run++;
    else begin if (wr_run != 0) last_wr = wr_run; wr_run = 0; end
    if (bus.eim_oe_n === 1'b0) oe_run++;
    else begin if (oe_run != 0) last_oe = oe_run; oe_run = 0; end
    if (bus.eim_cs0_n === 1'b1) cs_run++;
    else begin if (cs_run != 0) last_gap = cs_run; cs_run = 0; end
    if (!rst && bus.eim_da_oe === 1'b1 && bus.eim_oe_n === 1'b0) contention++;
    if (!rst && bus.eim_bclk !== 1'b0) bclk_bad++;
  end

  // Response monitor
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got rsp_valid with empty scoreboard (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
        chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.we ? last_rdata : e.rdata));
        if (!e.we) last_rdata = e.rdata;
        chk("rsp_latency", cyc - e.acc + 1, e.lat);
      end
    end
  end

  // Issue one command; the expected response follows from the protocol's phase budget
  task automatic issue(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                       input int unsigned nwait, input bit hold, input bit tmo, input bit keep,
                       output int unsigned acc);
    exp_t e;
    logic rdy;
    bit   ok = 1'b0;
    acc = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    for (int i = 0; i < 100; i++) begin
      rdy = bus.cmd_ready;
      acc = cyc + 1;
      @(posedge clk);
      if (rdy === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: cmd_ready never seen for addr %0h", addr);
      bus.cmd_valid = 1'b0;
      return;
    end
    e.we    = we;
    e.acc   = acc;
    e.err   = tmo;
    e.lat   = we ? 4 * P + 1 + nwait : (tmo ? 2 * P + T + 1 + WM : 3 * P + T + 1 + nwait);
    e.rdata = (we || tmo) ? 8'h00 : ref_mem[addr];
    if (keep) begin
      sbq.push_back(e);
      if (we) ref_mem[addr] = wdata;
    end
    #1;
    if (!hold) bus.cmd_valid = 1'b0;
    if (nwait != 0) begin
      repeat (we ? 7 : 9) @(posedge clk);
      #1 bus.eim_wait_n = 1'b0;
      repeat (nwait) @(posedge clk);
      #1 bus.eim_wait_n = 1'b1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sbq.size() == 0) break;
    end
    chk("drain_pending", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned a1, a2;
    for (int i = 0; i < 256; i++) begin
      tmem[i]    = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    bus.cmd_valid  = 1'b0;
    bus.cmd_we     = 1'b0;
    bus.cmd_addr   = 8'h00;
    bus.cmd_wdata  = 8'h00;
    bus.eim_wait_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ctrl", {bus.eim_cs0_n, bus.eim_lba_n, bus.eim_wr_n, bus.eim_oe_n, bus.eim_da_oe,
                       bus.rsp_valid, bus.rsp_err, bus.cmd_ready}, 8'b1111_0001);
    chk("reset_da_o", 32'(bus.eim_da_o), 32'd0);
    chk("reset_rdata", 32'(bus.rsp_rdata), 32'd0);

    // Write 0xA5 @0x00: address phase visible in the first clock after accept
    issue(1'b1, 8'h00, 8'hA5, 0, 1'b0, 1'b0, 1'b1, a1);
    @(negedge clk);
    chk("addr_phase", {bus.eim_cs0_n, bus.eim_lba_n, bus.eim_da_oe, bus.eim_da_o}, {3'b001, 8'h00});
    drain();
    repeat (2) @(negedge clk);
    chk("write_wr_low_len", last_wr, P);
    chk("target_mem0", 32'(tmem[0]), 32'hA5);

    // Read back @0x00: DA released through TURN
    issue(1'b0, 8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b1, a1);
    repeat (9) @(negedge clk);
    chk("turn_released", {bus.eim_da_oe, bus.eim_oe_n, bus.eim_cs0_n}, 3'b010);
    drain();
    repeat (2) @(negedge clk);
    chk("read_oe_low_len", last_oe, P);

    // cmd_valid held across a write then read to the same address
    issue(1'b1, 8'h01, 8'h3C, 0, 1'b1, 1'b0, 1'b1, a1);
    issue(1'b0, 8'h01, 8'h00, 0, 1'b0, 1'b0, 1'b1, a2);
    chk("held_accept_gap", a2 - a1, 5 * P + 1);
    drain();
    chk("cs_high_gap", last_gap, P + 1);

    // Write stretched by six wait clocks in WDATA
    issue(1'b1, 8'h05, 8'h5A, 6, 1'b0, 1'b0, 1'b1, a1);
    drain();
    repeat (2) @(negedge clk);
    chk("wait_wr_low_len", last_wr, P + 6);

    // Read with wait held low: timeout abort, then a normal read
    @(negedge clk);
    bus.eim_wait_n = 1'b0;
    issue(1'b0, 8'h02, 8'h00, 0, 1'b0, 1'b1, 1'b1, a1);
    drain();
    bus.eim_wait_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_timeout_ready", 32'(bus.cmd_ready), 32'd1);
    issue(1'b0, 8'h05, 8'h00, 0, 1'b0, 1'b0, 1'b1, a1);
    drain();

    // Reset while in WDATA: transaction dropped, target untouched
    issue(1'b1, 8'h03, 8'h77, 0, 1'b0, 1'b0, 1'b0, a1);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    last_rdata = 8'h00;
    @(negedge clk);
    chk("mid_reset_ctrl", {bus.eim_cs0_n, bus.eim_lba_n, bus.eim_wr_n, bus.eim_oe_n, bus.eim_da_oe,
                           bus.rsp_valid, bus.rsp_err, bus.cmd_ready}, 8'b1111_0001);
    repeat (30) @(negedge clk);
    issue(1'b0, 8'h03, 8'h00, 0, 1'b0, 1'b0, 1'b1, a1);
    drain();

    // Random traffic over a small address window, with occasional wait stretches
    for (int n = 0; n < 40; n++) begin
      logic        we;
      logic [7:0]  ad, wd;
      int unsigned nw;
      we = 1'($urandom_range(0, 1));
      ad = 8'($urandom_range(0, 15));
      wd = 8'($urandom);
      nw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
      issue(we, ad, wd, nw, 1'b0, 1'b0, 1'b1, a1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();
    repeat (5) @(negedge clk);
    chk("bus_contention", contention, 0);
    chk("bclk_low", bclk_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
